// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared state type and parameter defaults for the UART transmit arbiter
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT,
    HOLD
  } uart_arb_state_t;

  localparam int UART_ARB_NUM_REQ        = 4;
  localparam int UART_ARB_TIMEOUT_CYCLES = 24000;

endpackage

// File: rtl/uart_rr_pick.sv
// rtl/uart_rr_pick.sv - combinational round-robin search upward from last_grant+1
module uart_rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant,
  output logic [$clog2(NUM_REQ)-1:0] pick_id,
  output logic                       pick_any
);

  localparam int IDW = $clog2(NUM_REQ);

  // Scan from the farthest candidate back to the nearest so the nearest valid one wins.
  always_comb begin
    int idx;
    logic [IDW-1:0] cand;
    idx      = 0;
    cand     = '0;
    pick_id  = '0;
    pick_any = |req_valid;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = int'(last_grant) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = IDW'(idx);
      if (req_valid[cand]) pick_id = cand;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-granular round-robin sharing of one uart_tx among requesters
// Optional HOLD idle timeout compiled in with UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ        = UART_ARB_NUM_REQ,
  parameter int TIMEOUT_CYCLES = UART_ARB_TIMEOUT_CYCLES
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*8-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       tx_start,
  output logic [7:0]                 tx_din,
  input  logic                       tx_done_tick,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy
);

  localparam int IDW = $clog2(NUM_REQ);

  uart_arb_state_t state_q, state_d;
  logic [IDW-1:0]  grant_q;
  logic [IDW-1:0]  last_grant_q;
  logic [7:0]      tx_din_q;
  logic            last_q;
  logic [IDW-1:0]  pick_id;
  logic            pick_any;
  logic            rel_lock;
  logic            timeout;

  uart_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_valid  (req_valid),
    .last_grant (last_grant_q),
    .pick_id    (pick_id),
    .pick_any   (pick_any)
  );

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] hold_cnt_q;

  // Counts consecutive HOLD cycles; any exit from HOLD rearms it.
  always_ff @(posedge clk) begin
    if (reset || state_q != HOLD || state_d != HOLD) hold_cnt_q <= '0;
    else                                             hold_cnt_q <= hold_cnt_q + CW'(1);
  end

  assign timeout = (state_q == HOLD) && (hold_cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    rel_lock  = 1'b0;
    req_ready = '0;
    case (state_q)
      IDLE: if (pick_any) state_d = LOAD;
      LOAD: begin
        req_ready[grant_q] = 1'b1;
        state_d = WAIT;
      end
      WAIT: if (tx_done_tick) begin
        if (last_q) begin
          state_d  = IDLE;
          rel_lock = 1'b1;
        end else begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (req_valid[grant_q]) begin
          state_d = LOAD;
        end else if (timeout) begin
          state_d  = IDLE;
          rel_lock = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= IDW'(NUM_REQ - 1);
      tx_din_q     <= 8'h00;
      last_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && pick_any) begin
        grant_q  <= pick_id;
        tx_din_q <= req_data[{pick_id, 3'b000} +: 8];
      end
      if (state_q == HOLD && state_d == LOAD) tx_din_q <= req_data[{grant_q, 3'b000} +: 8];
      if (state_q == LOAD) last_q <= req_last[grant_q];
      if (rel_lock) last_grant_q <= grant_q;
    end
  end

  assign tx_start = (state_q == LOAD);
  assign tx_din   = tx_din_q;
  assign grant_id = grant_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter with a stubbed uart_tx
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        tx_start;
  logic [7:0]  tx_din;
  logic        tx_done_tick;
  logic [1:0]  grant_id;
  logic        busy;

  logic        stub_tick, spur_tick;
  assign tx_done_tick = stub_tick | spur_tick;

  uart_tx_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(50)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .tx_start     (tx_start),
    .tx_din       (tx_din),
    .tx_done_tick (tx_done_tick),
    .grant_id     (grant_id),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [8:0] stg   [4][$];
  logic [8:0] drv_q [4][$];
  logic [8:0] mq    [4][$];
  logic [9:0] exp_q [$];
  logic [3:0] pop_mask = '0;
  int         m_lg = 3;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  function automatic bit drv_empty();
    for (int i = 0; i < 4; i++) if (drv_q[i].size() > 0) return 1'b0;
    return 1'b1;
  endfunction

  // Reference: owners served in round-robin order over requesters holding complete packets.
  task automatic launch();
    int owner;
    logic [8:0] b;
    bit done;
    for (int i = 0; i < 4; i++) begin
      mq[i] = stg[i];
      for (int j = 0; j < stg[i].size(); j++) drv_q[i].push_back(stg[i][j]);
      stg[i].delete();
    end
    done = 1'b0;
    while (!done) begin
      owner = -1;
      for (int k = 1; k <= 4; k++)
        if (owner < 0 && mq[(m_lg + k) % 4].size() > 0) owner = (m_lg + k) % 4;
      if (owner < 0) done = 1'b1;
      else begin
        b = 9'h000;
        while (mq[owner].size() > 0 && !b[8]) begin
          b = mq[owner].pop_front();
          exp_q.push_back({owner[1:0], b[7:0]});
        end
        if (b[8]) m_lg = owner;
        else done = 1'b1;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) drv_q[i].delete();
    exp_q.delete();
    pop_mask = '0;
    m_lg = 3;
    step(2);
    reset = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() > 0 || busy || !drv_empty()) && n < budget) begin
      step(1);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_drain: %0d transfers still expected after %0d cycles, required 0", name, exp_q.size(), budget);
    end
  endtask

  task automatic wait_start(input string name, input int budget);
    int n = 0;
    while (!tx_start && n < budget) begin
      step(1);
      n++;
    end
    checks++;
    if (!tx_start) begin
      errors++;
      $display("FAIL %s_start: tx_start not seen within %0d cycles", name, budget);
    end
  endtask

  // Requester models: hold each byte until its ready pulse, then present the next one.
  initial begin
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++)
        if (pop_mask[i] && drv_q[i].size() > 0) void'(drv_q[i].pop_front());
      pop_mask = reset ? 4'h0 : req_ready;
      for (int i = 0; i < 4; i++) begin
        if (drv_q[i].size() > 0) begin
          req_valid[i]       = 1'b1;
          req_data[8*i +: 8] = drv_q[i][0][7:0];
          req_last[i]        = drv_q[i][0][8];
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
  end

  // uart_tx stub: done tick 10 cycles after each start.
  initial begin
    int cnt = 0;
    stub_tick = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        cnt = 0;
        stub_tick = 1'b0;
      end else if (tx_start) begin
        cnt = 10;
        stub_tick = 1'b0;
      end else if (cnt > 0) begin
        cnt--;
        stub_tick = (cnt == 0);
      end else begin
        stub_tick = 1'b0;
      end
    end
  end

  initial begin
    logic prev = 1'b0;
    logic [9:0] e;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev = 1'b0;
      end else begin
        if (tx_start) begin
          chk("tx_start_single_cycle", {31'd0, prev}, 32'd0);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_tx: got id %0d data %02h, required no transfer", grant_id, tx_din);
          end else begin
            e = exp_q.pop_front();
            chk("tx_grant_id", {30'd0, grant_id}, {30'd0, e[9:8]});
            chk("tx_din", {24'd0, tx_din}, {24'd0, e[7:0]});
            chk("req_ready", {28'd0, req_ready}, 32'd1 << e[9:8]);
          end
        end else if (req_ready != 4'h0) begin
          chk("req_ready_outside_load", {28'd0, req_ready}, 32'd0);
        end
        prev = tx_start;
      end
    end
  end

  initial begin
    spur_tick = 1'b0;
    reset = 1'b1;
    step(3);
    chk("rst_tx_start", {31'd0, tx_start}, 0);
    chk("rst_tx_din", {24'd0, tx_din}, 0);
    chk("rst_req_ready", {28'd0, req_ready}, 0);
    chk("rst_grant_id", {30'd0, grant_id}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    reset = 1'b0;
    step(1);

    // Single byte: LOAD one cycle after valid, idle again 12 cycles after valid.
    stg[0].push_back({1'b1, 8'h64});
    launch();
    step(1);
    step(1);
    chk("single_tx_start", {31'd0, tx_start}, 1);
    step(10);
    chk("single_busy_high", {31'd0, busy}, 1);
    step(1);
    chk("single_busy_low", {31'd0, busy}, 0);
    drain("single", 200);

    // Contention from a fresh reset, twice.
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) stg[i].push_back({1'b1, 8'hA0 + 8'(i)});
      launch();
      drain("contention", 400);
    end

    // Packet lock: req2 waits behind the whole req1 packet.
    stg[1].push_back({1'b0, 8'h66});
    stg[1].push_back({1'b0, 8'h6F});
    stg[1].push_back({1'b1, 8'h6F});
    stg[2].push_back({1'b1, 8'h21});
    launch();
    drain("lock", 400);

    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < 4; i++) begin
        int npk = $urandom_range(0, 2);
        for (int q = 0; q < npk; q++) begin
          int len = $urandom_range(1, 3);
          for (int b = 0; b < len; b++) stg[i].push_back({(b == len - 1), 8'($urandom)});
        end
      end
      launch();
      drain("random", 2000);
    end

    // Spurious done tick while idle.
    spur_tick = 1'b1;
    step(1);
    spur_tick = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("spur_idle_busy", {31'd0, busy}, 0);
      chk("spur_idle_tx_start", {31'd0, tx_start}, 0);
      step(1);
    end

    // Reset during WAIT, then requester 0 wins.
    stg[2].push_back({1'b0, 8'h31});
    stg[2].push_back({1'b1, 8'h32});
    launch();
    wait_start("rst_mid", 50);
    step(2);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) drv_q[i].delete();
    exp_q.delete();
    step(1);
    chk("midrst_tx_start", {31'd0, tx_start}, 0);
    chk("midrst_tx_din", {24'd0, tx_din}, 0);
    chk("midrst_req_ready", {28'd0, req_ready}, 0);
    chk("midrst_grant_id", {30'd0, grant_id}, 0);
    chk("midrst_busy", {31'd0, busy}, 0);
    reset = 1'b0;
    m_lg = 3;
    pop_mask = '0;
    stg[1].push_back({1'b1, 8'h41});
    stg[0].push_back({1'b1, 8'h40});
    launch();
    drain("after_reset", 400);

    // Requester 3 stalls after a non-last byte.
    stg[3].push_back({1'b0, 8'h77});
    launch();
    wait_start("stall", 50);
    step(11);
    chk("stall_hold_busy", {31'd0, busy}, 1);
    spur_tick = 1'b1;
    step(1);
    spur_tick = 1'b0;
    chk("spur_hold_tx_start", {31'd0, tx_start}, 0);
`ifdef UART_ARB_TIMEOUT_EN
    m_lg = 3;
    stg[0].push_back({1'b1, 8'h5A});
    launch();
    step(48);
    chk("timeout_busy_before", {31'd0, busy}, 1);
    step(1);
    chk("timeout_idle", {31'd0, busy}, 0);
    drain("timeout", 200);
`else
    step(100);
    chk("stall_busy_held", {31'd0, busy}, 1);
    chk("stall_no_start", {31'd0, tx_start}, 0);
    chk("stall_expect_empty", exp_q.size(), 0);
    do_reset();
`endif

    step(5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one `uart_tx` serializer among `NUM_REQ` byte-stream requesters (command echo, status reporter, debug dump) in the UART top level. Grants are round-robin at packet granularity: a granted requester keeps the transmitter until it sends a byte flagged `last`. The block issues `tx_start` and `din` to `uart_tx` and advances on `tx_done_tick`.

## Interface

Parameters:
- `NUM_REQ`, default 4: number of requesters, 2–8.
- `TIMEOUT_CYCLES`, default 24000: HOLD-state idle limit in clocks. At 12 MHz this is 2 ms. Used only with the timeout macro.

Ports:
- `clk`: input, 1 bit. System clock, 12 MHz.
- `reset`: input, 1 bit. Synchronous, active-high.
- `req_valid`: input, `NUM_REQ` bits. Requester i presents a byte.
- `req_data`: input, `NUM_REQ*8` bits. Byte of requester i is at `[8i+7:8i]`.
- `req_last`: input, `NUM_REQ` bits. The presented byte ends the packet.
- `req_ready`: output, `NUM_REQ` bits. One-cycle accept pulse to requester i.
- `tx_start`: output, 1 bit. To `uart_tx`.
- `tx_din`: output, 8 bits. To `uart_tx` `din`.
- `tx_done_tick`: input, 1 bit. From `uart_tx`.
- `grant_id`: output, `$clog2(NUM_REQ)` bits. Current or most recent owner.
- `busy`: output, 1 bit. High when the FSM is not in IDLE.

## Operation

- Handshake: a requester holds `req_valid`, `req_data` and `req_last` stable until its `req_ready` pulses. The byte is consumed in the pulse cycle.
- State machine: IDLE, LOAD, WAIT, HOLD.
  - IDLE: if any `req_valid` is set, pick the first set bit searching upward from `last_grant+1` modulo `NUM_REQ`. Register it into `grant_id` and go to LOAD. If no `req_valid` is set, stay in IDLE.
  - LOAD (1 cycle): `tx_start`=1. `tx_din` is registered with the granted byte. `req_ready[grant_id]`=1. `req_last` is latched. Go to WAIT.
  - WAIT: on `tx_done_tick`, go to IDLE if the latched last is set, and update `last_grant` to `grant_id`. Otherwise go to HOLD. `tx_done_tick` is ignored in every other state.
  - HOLD: if `req_valid[grant_id]` is set, go to LOAD. Other requesters are ignored until the packet ends.
- Reset values: state IDLE, `tx_start`=0, `tx_din`=8'h00, `req_ready`=0, `grant_id`=0, `busy`=0, `last_grant`=`NUM_REQ-1`. Requester 0 therefore wins the first arbitration.
- Reset mid-packet returns to IDLE immediately and discards the locked packet. `uart_tx` shares the same reset.
- Simultaneous requests: exactly one grant per arbitration. Losing requesters keep `valid` asserted and are not acknowledged.
- A requester that drops `valid` in HOLD without having sent `last` stalls the arbiter. This is the intended behaviour unless the timeout macro is compiled in.

## Timing

- `req_valid` rises in cycle t while in IDLE: LOAD is in cycle t+1, with `tx_start`, `req_ready` and `tx_din` valid together.
- `tx_done_tick` in cycle u ends a mid-packet byte. If the next byte is already valid, LOAD is in cycle u+2 (HOLD in u+1).
- `tx_done_tick` in cycle u ends a packet. If another request is pending, the next LOAD is in cycle u+2 (IDLE in u+1).
- `tx_start` is never high for more than one consecutive cycle.
- `busy` is high from the first LOAD through the cycle in which the FSM returns to IDLE (exclusive).

## Configuration

- Macro: `UART_ARB_TIMEOUT_EN`.
- Defined: a counter clears on entry to HOLD and increments each HOLD cycle.
  - When it reaches `TIMEOUT_CYCLES-1` with no valid, the FSM goes to IDLE and updates `last_grant`, releasing the lock.
  - Leaving HOLD for LOAD clears the counter.
- Undefined: no counter is instantiated. HOLD waits indefinitely.

## Structure

- Package `uart_arb_pkg` holds:
  - the state enum `uart_arb_state_t` (IDLE, LOAD, WAIT, HOLD);
  - the default `NUM_REQ`;
  - the default `TIMEOUT_CYCLES`.
- Sub-module `uart_rr_pick`: combinational round-robin priority search.
  - Inputs: `req_valid` and `last_grant`.
  - Outputs: `pick_id` and `pick_any`.

## Test plan

The bench stubs `uart_tx`: `tx_done_tick` pulses 10 cycles after each `tx_start`.

- Single request: req0 sends 8'h64 with `last` → one `tx_start`, `tx_din`=8'h64, `req_ready[0]` in the same cycle, `grant_id`=0, `busy` low 12 cycles later.
- Contention: all four requesters send a 1-byte packet at once (8'hA0–8'hA3) → transmit order 0,1,2,3. A repeat of the same stimulus gives order 0,1,2,3 again after the wrap.
- Packet lock: req1 sends 8'h66, 8'h6F, 8'h6F (last on the third) while req2 is valid throughout → all three req1 bytes are sent before req2. No `req_ready[2]` pulses during the packet.
- Stall in HOLD: req3 drops `valid` after its first non-last byte.
  - Without the macro: `busy` stays high.
  - With `UART_ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=50: IDLE 50 cycles after HOLD entry, and req0 is served next.
- Reset mid-packet: assert `reset` during WAIT → next cycle all outputs at reset values. The next arbitration favours requester 0.
- Spurious `tx_done_tick` in IDLE or HOLD → no state change, no `tx_start`.
